// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches a word from instruction memory, waits for the
// datapath to finish it, then redirects the PC or halts. Every output is a flop.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        exec_done,
  input  logic        halt_req,
  input  logic [31:0] pc_new,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic [31:0] retired
);

  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StFetch  = 2'b01;
  localparam logic [1:0] StExec   = 2'b10;
  localparam logic [1:0] StHalted = 2'b11;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    retired_d     = retired_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFetch;
          imem_req_d = 1'b1;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d       = imem_data;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          // retired wraps naturally at 2^32.
          retired_d = retired_q + 32'd1;
          if (halt_req) begin
            state_d = StHalted;
          end else begin
            pc_d       = {pc_new[31:2], 2'b00};
            imem_req_d = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      default: begin
        // Halted: only reset leaves this state.
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= ResetPcAligned;
      imem_req_q    <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      retired_q     <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot, branch, stall, halt, mid-fetch reset, counter wrap.
module tb_fetch_sequencer;

  localparam logic [31:0] RstPc  = 32'h0000_1003;
  localparam logic [31:0] RstPcA = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, exec_done, halt_req;
  logic [31:0] imem_data, pc_new;
  logic [31:0] pc, imem_addr, instr, retired;
  logic        imem_req, instr_valid;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.RESET_PC(RstPc)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .exec_done  (exec_done),
    .halt_req   (halt_req),
    .pc_new     (pc_new),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .state      (state),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
    imem_data = 32'h0; pc_new = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_pc", pc, RstPcA);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rst_retired", retired, 32'd0);

    // Idle holds without start; spurious ack/done ignored.
    imem_ack = 1'b1; exec_done = 1'b1; imem_data = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0; exec_done = 1'b0;
    check("idle_hold", {30'd0, state}, 32'd0);
    check("idle_instr", instr, 32'd0);

    // Boot: ack on second fetch cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("boot_state", {30'd0, state}, 32'd1);
    check("boot_req", {31'd0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, RstPcA);
    tick();
    check("fetch1_state", {30'd0, state}, 32'd1);
    imem_ack = 1'b1; imem_data = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("fetch_instr", instr, 32'h1234_5678);
    check("fetch_ivalid", {31'd0, instr_valid}, 32'd1);
    check("fetch_state", {30'd0, state}, 32'd2);
    check("fetch_req", {31'd0, imem_req}, 32'd0);

    // Spurious ack in EXEC.
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("exec_ivalid_pulse", {31'd0, instr_valid}, 32'd0);
    check("exec_spur_instr", instr, 32'h1234_5678);
    check("exec_spur_state", {30'd0, state}, 32'd2);
    check("exec_spur_pc", pc, RstPcA);
    check("exec_spur_ret", retired, 32'd0);

    // Branch.
    pc_new = 32'h0000_0103; exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("br_pc", pc, 32'h0000_0100);
    check("br_addr", imem_addr, 32'h0000_0100);
    check("br_retired", retired, 32'd1);
    check("br_state", {30'd0, state}, 32'd1);
    check("br_req", {31'd0, imem_req}, 32'd1);

    // Stall five cycles, with spurious exec_done in FETCH.
    exec_done = 1'b1; pc_new = 32'h0000_0F00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, 32'h0000_0100);
      check("stall_instr", instr, 32'h1234_5678);
      check("stall_state", {30'd0, state}, 32'd1);
      check("stall_ret", retired, 32'd1);
    end
    exec_done = 1'b0;

    imem_ack = 1'b1; imem_data = 32'hA5A5_0001;
    tick();
    imem_ack = 1'b0;
    check("f2_instr", instr, 32'hA5A5_0001);

    // Halt.
    exec_done = 1'b1; halt_req = 1'b1; pc_new = 32'h0000_2000;
    tick();
    exec_done = 1'b0; halt_req = 1'b0;
    check("halt_state", {30'd0, state}, 32'd3);
    check("halt_pc", pc, 32'h0000_0100);
    check("halt_req_out", {31'd0, imem_req}, 32'd0);
    check("halt_ret", retired, 32'd2);
    start = 1'b1; imem_ack = 1'b1; exec_done = 1'b1;
    tick(); tick();
    start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    check("halt_sticky", {30'd0, state}, 32'd3);
    check("halt_sticky_pc", pc, 32'h0000_0100);
    check("halt_sticky_ret", retired, 32'd2);

    // Reset out of HALTED, then reset mid-fetch with a concurrent ack.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_state", {30'd0, state}, 32'd0);
    check("rst2_ret", retired, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mf_pre_state", {30'd0, state}, 32'd1);
    rst = 1'b1; imem_ack = 1'b1; imem_data = 32'hFFFF_0000;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    check("mf_state", {30'd0, state}, 32'd0);
    check("mf_instr", instr, 32'd0);
    check("mf_ivalid", {31'd0, instr_valid}, 32'd0);
    check("mf_pc", pc, RstPcA);
    check("mf_req", {31'd0, imem_req}, 32'd0);

    // Preset retired to all-ones, then retire one instruction to wrap.
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    tick();
    check("wrap_preset", retired, 32'hFFFF_FFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    imem_ack = 1'b1; imem_data = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    exec_done = 1'b1; pc_new = 32'h0000_0012;
    tick();
    exec_done = 1'b0;
    check("wrap_ret", retired, 32'd0);
    check("wrap_pc", pc, 32'h0000_0010);
    check("wrap_state", {30'd0, state}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
